timer_reload_seq: RTL and testbench
===================================

# timer_reload_seq

APB-master sequencer that autonomously programs and re-arms the 8-bit timer through its TDR/TCR/TSR register interface. On `arm` it loads a reload value, starts the timer, then services each overflow/underflow: verify flag, clear TSR, reload, restart. It repeats until a programmed reload count is reached or `stop` is asserted. It sits between the timer's interrupt lines and a second APB master port on the timer's register bus, offloading periodic re-arm from the CPU.

## Interface
- `ADDR_TDR`, default 8'h00: TDR address.
- `ADDR_TCR`, default 8'h01: TCR address.
- `ADDR_TSR`, default 8'h02: TSR address.
- `pclk`  in  1  clock; one clock domain.
- `presetn`  in  1  asynchronous, active-low reset.
- `arm`  in  1  start pulse; sampled only in IDLE.
- `stop`  in  1  abort request; sampled every cycle.
- `reload_val`  in  8  value written to TDR; captured on `arm`.
- `tcr_val`  in  8  TCR run image (bits 7 and 4 forced by the block); captured on `arm`.
- `reload_cnt`  in  8  reloads to perform; 0 = unlimited; captured on `arm`.
- `tmr_ovf`, `tmr_udf`  in  1 each  timer interrupt levels.
- `psel`, `penable`, `pwrite`  out  1 each  APB master controls.
- `paddr`  out  8  APB address.
- `pwdata`  out  8  APB write data.
- `prdata`  in  8  APB read data.
- `pready`, `pslverr`  in  1 each  APB completion and error.
- `busy`  out  1  high from the cycle after `arm` until return to IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `err`  out  1  sticky; set on `pslverr`; cleared by the next accepted `arm`.
- `spur_cnt`  out  8  spurious events seen; saturates at 8'hFF; cleared on `arm`.
- `reloads_done`  out  8  reloads completed; cleared on `arm`.

## Operation
- States: IDLE, WR_TDR, WR_LD, WR_RUN, WAIT, RD_TSR, WR_CLR, WR_OFF.
- Sequence of transfers:
  - WR_TDR: write `reload_val` to TDR.
  - WR_LD: write `tcr_val|8'h80` to TCR.
  - WR_RUN: write `(tcr_val&8'h7F)|8'h10` to TCR.
  - WAIT entered after WR_RUN.
- WAIT:
  - `tmr_ovf|tmr_udf` high -> RD_TSR.
  - `stop` -> WR_OFF.
  - `stop` has priority over a same-cycle event.
- RD_TSR:
  - `prdata[1:0]==0` -> spurious event: `spur_cnt`+1, back to WAIT.
  - Otherwise -> WR_CLR.
- WR_CLR: write 8'h00 to TSR.
  - If `reload_cnt!=0 && reloads_done==reload_cnt` -> WR_OFF.
  - Else -> WR_TDR (reload pass).
- `reloads_done` increments at completion of WR_RUN on reload passes only, not on the initial arm.
- WR_OFF: write `tcr_val&8'h6F` (load and enable cleared) to TCR, then IDLE.
  - `done` pulses when WR_OFF was reached by count completion, not by `stop`.
- `stop` outside WAIT: the current transfer completes, then WR_OFF. No further transfers in between.
- `pslverr` on any transfer: set `err`, drop the bus, go to IDLE immediately. No WR_OFF, no `done`.
- `arm` while busy is ignored.
- Both flags set at once: serviced once; the single clear write covers both.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - Asserting reset mid-transfer drops `psel`/`penable` immediately. The aborted transfer is lost.
- Every transfer has two phases:
  - Setup: `psel=1`, `penable=0` for one cycle.
  - Access: `penable=1`, held until `pready`.
  - `paddr`/`pwrite`/`pwdata` are stable across both phases.
- Latency and spacing:
  - `arm` in cycle N -> setup of WR_TDR in cycle N+1.
  - Back-to-back transfers: the next setup is the cycle after `pready`. Minimum 2 cycles per transfer.
  - WAIT detects the event in cycle M -> RD_TSR setup in M+1.
- `prdata` is sampled in the access cycle where `pready=1`.
- `busy` falls in the cycle IDLE is entered. `done` is coincident with that cycle.

## Configuration
- Macro: `TIMER_RELOAD_SEQ_SPUR_CHK_EN`.
- Defined: RD_TSR is present, and fake events are filtered as above.
- Undefined:
  - RD_TSR is omitted; WAIT goes directly to WR_CLR on any event.
  - `spur_cnt` is tied to 0.

## Structure
- Shared package `timer_pkg`:
  - Default register addresses.
  - TCR bit positions (LOAD=7, EN=4).
  - TSR bit positions (OVF=0, UDF=1).
  - State enum.
- Sub-module `apb_mst_xfer`:
  - Single-transfer engine: `start`/`wr`/`addr`/`wdata` in; `done`/`rdata`/`slverr` out.
  - Owns the setup/access phases.
- The top-level FSM sequences the command states only.

## Test plan
- Arm with `reload_val`=8'hF0, `tcr_val`=8'h00, `reload_cnt`=2, zero-wait slave -> writes TDR=F0, TCR=80, TCR=10. Each event then gives read TSR, TSR=00, TDR=F0, TCR=80, TCR=10. Third event ends with TCR=00, `done` pulse, `reloads_done`=2.
- Pulse `tmr_udf` while slave TSR reads 8'h00 -> `spur_cnt`=1, no TSR write, stays in WAIT. Macro undefined -> TSR=00 written immediately instead.
- `stop` in WAIT, same cycle as `tmr_ovf` -> only TCR=00 written, then IDLE, no `done`.
- `pslverr` on WR_LD -> `err`=1, bus idle next cycle, IDLE. Next `arm` clears `err`.
- `pready` low for 3 access cycles on each transfer -> address/data held and no transfer skipped. Deassert `presetn` mid-access -> all outputs 0 at once.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer re-arm sequencer: register map defaults,
// TCR/TSR bit positions and the sequencer state encoding.
package timer_pkg;

    localparam logic [7:0] ADDR_TDR_DEF = 8'h00;
    localparam logic [7:0] ADDR_TCR_DEF = 8'h01;
    localparam logic [7:0] ADDR_TSR_DEF = 8'h02;

    localparam int TCR_LOAD_BIT = 7;
    localparam int TCR_EN_BIT   = 4;
    localparam int TSR_OVF_BIT  = 0;
    localparam int TSR_UDF_BIT  = 1;

    localparam logic [7:0] TCR_LOAD_MASK = 8'(1 << TCR_LOAD_BIT);
    localparam logic [7:0] TCR_EN_MASK   = 8'(1 << TCR_EN_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_TDR,
        S_WR_LD,
        S_WR_RUN,
        S_WAIT,
        S_RD_TSR,
        S_WR_CLR,
        S_WR_OFF
    } state_t;

endpackage

// File: rtl/timer_reload_seq_if.sv
// APB register-bus bundle between the sequencer (master) and the timer (slave).
interface timer_reload_seq_if;

    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/timer_reload_seq_apb_mst_xfer.sv
// Single APB transfer engine: while start_i is held it runs one setup phase
// followed by access phases until pready, then pulses done_o.
module apb_mst_xfer (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       wr_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic       slverr_o,
    timer_reload_seq_if.master apb
);

    logic access_q, access_d;

    always_comb begin
        access_d = access_q;
        if (!start_i) begin
            access_d = 1'b0;
        end else if (!access_q) begin
            access_d = 1'b1;
        end else if (apb.pready) begin
            access_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            access_q <= 1'b0;
        end else begin
            access_q <= access_d;
        end
    end

    // Bus drives are gated by start_i so a reset of the caller drops the bus at once.
    assign apb.psel    = start_i;
    assign apb.penable = start_i & access_q;
    assign apb.pwrite  = start_i & wr_i;
    assign apb.paddr   = start_i ? addr_i  : 8'h00;
    assign apb.pwdata  = start_i ? wdata_i : 8'h00;

    assign done_o   = start_i & access_q & apb.pready;
    assign rdata_o  = apb.prdata;
    assign slverr_o = done_o & apb.pslverr;

endmodule

// File: rtl/timer_reload_seq.sv
// Autonomous APB re-arm sequencer for the 8-bit timer.
// Build option: TIMER_RELOAD_SEQ_SPUR_CHK_EN enables the TSR read that filters spurious events.
module timer_reload_seq
    import timer_pkg::*;
#(
    parameter logic [7:0] ADDR_TDR = ADDR_TDR_DEF,
    parameter logic [7:0] ADDR_TCR = ADDR_TCR_DEF,
    parameter logic [7:0] ADDR_TSR = ADDR_TSR_DEF
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       arm,
    input  logic       stop,
    input  logic [7:0] reload_val,
    input  logic [7:0] tcr_val,
    input  logic [7:0] reload_cnt,
    input  logic       tmr_ovf,
    input  logic       tmr_udf,
    timer_reload_seq_if.master apb,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] spur_cnt,
    output logic [7:0] reloads_done
);

    state_t     state_q, state_d;
    logic [7:0] reload_val_q, tcr_val_q, reload_cnt_q, reloads_done_q;
    logic       stop_pend_q, reload_pass_q, by_count_q, err_q, done_q;

    logic       xfer_start, xfer_wr, xfer_done, xfer_slverr;
    logic [7:0] xfer_addr, xfer_wdata, xfer_rdata;
    logic       stop_seen, count_hit, tsr_flagged, accept_arm;

    assign accept_arm  = (state_q == S_IDLE) && arm;
    assign stop_seen   = stop | stop_pend_q;
    assign count_hit   = (reload_cnt_q != 8'h00) && (reloads_done_q == reload_cnt_q);
    assign tsr_flagged = xfer_rdata[TSR_OVF_BIT] | xfer_rdata[TSR_UDF_BIT];

    apb_mst_xfer u_xfer (
        .clk_i    (pclk),
        .rst_ni   (presetn),
        .start_i  (xfer_start),
        .wr_i     (xfer_wr),
        .addr_i   (xfer_addr),
        .wdata_i  (xfer_wdata),
        .done_o   (xfer_done),
        .rdata_o  (xfer_rdata),
        .slverr_o (xfer_slverr),
        .apb      (apb)
    );

    always_comb begin
        state_d    = state_q;
        xfer_start = 1'b0;
        xfer_wr    = 1'b1;
        xfer_addr  = 8'h00;
        xfer_wdata = 8'h00;
        unique case (state_q)
            S_IDLE: begin
                if (arm) state_d = S_WR_TDR;
            end
            S_WR_TDR: begin
                xfer_start = 1'b1;
                xfer_addr  = ADDR_TDR;
                xfer_wdata = reload_val_q;
                if (xfer_done) state_d = stop_seen ? S_WR_OFF : S_WR_LD;
            end
            S_WR_LD: begin
                xfer_start = 1'b1;
                xfer_addr  = ADDR_TCR;
                xfer_wdata = tcr_val_q | TCR_LOAD_MASK;
                if (xfer_done) state_d = stop_seen ? S_WR_OFF : S_WR_RUN;
            end
            S_WR_RUN: begin
                xfer_start = 1'b1;
                xfer_addr  = ADDR_TCR;
                xfer_wdata = (tcr_val_q & ~TCR_LOAD_MASK) | TCR_EN_MASK;
                if (xfer_done) state_d = stop_seen ? S_WR_OFF : S_WAIT;
            end
            S_WAIT: begin
                if (stop) begin
                    state_d = S_WR_OFF;
                end else if (tmr_ovf | tmr_udf) begin
`ifdef TIMER_RELOAD_SEQ_SPUR_CHK_EN
                    state_d = S_RD_TSR;
`else
                    state_d = S_WR_CLR;
`endif
                end
            end
            S_RD_TSR: begin
                xfer_start = 1'b1;
                xfer_wr    = 1'b0;
                xfer_addr  = ADDR_TSR;
                if (xfer_done) begin
                    if (stop_seen)        state_d = S_WR_OFF;
                    else if (tsr_flagged) state_d = S_WR_CLR;
                    else                  state_d = S_WAIT;
                end
            end
            S_WR_CLR: begin
                xfer_start = 1'b1;
                xfer_addr  = ADDR_TSR;
                xfer_wdata = 8'h00;
                if (xfer_done) state_d = (count_hit || stop_seen) ? S_WR_OFF : S_WR_TDR;
            end
            S_WR_OFF: begin
                xfer_start = 1'b1;
                xfer_addr  = ADDR_TCR;
                xfer_wdata = tcr_val_q & ~(TCR_LOAD_MASK | TCR_EN_MASK);
                if (xfer_done) state_d = S_IDLE;
            end
        endcase
        // A slave error abandons the sequence without switching the timer off.
        if (xfer_slverr) state_d = S_IDLE;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q        <= S_IDLE;
            reload_val_q   <= 8'h00;
            tcr_val_q      <= 8'h00;
            reload_cnt_q   <= 8'h00;
            reloads_done_q <= 8'h00;
            stop_pend_q    <= 1'b0;
            reload_pass_q  <= 1'b0;
            by_count_q     <= 1'b0;
            err_q          <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (accept_arm) begin
                reload_val_q   <= reload_val;
                tcr_val_q      <= tcr_val;
                reload_cnt_q   <= reload_cnt;
                reloads_done_q <= 8'h00;
                stop_pend_q    <= 1'b0;
                reload_pass_q  <= 1'b0;
                by_count_q     <= 1'b0;
                err_q          <= 1'b0;
            end else begin
                if (stop && state_q != S_IDLE) stop_pend_q <= 1'b1;
                if (xfer_slverr) err_q <= 1'b1;
                if (state_q == S_WR_RUN && xfer_done && !xfer_slverr && reload_pass_q)
                    reloads_done_q <= reloads_done_q + 8'd1;
                if (state_q == S_WR_CLR && xfer_done && !xfer_slverr) begin
                    reload_pass_q <= 1'b1;
                    by_count_q    <= count_hit;
                end
                if (state_q == S_WR_OFF && xfer_done && !xfer_slverr) done_q <= by_count_q;
                if (state_d == S_IDLE) stop_pend_q <= 1'b0;
            end
        end
    end

`ifdef TIMER_RELOAD_SEQ_SPUR_CHK_EN
    logic [7:0] spur_cnt_q;
    logic       spur_hit;

    assign spur_hit = (state_q == S_RD_TSR) && xfer_done && !xfer_slverr && !tsr_flagged;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            spur_cnt_q <= 8'h00;
        end else if (accept_arm) begin
            spur_cnt_q <= 8'h00;
        end else if (spur_hit && spur_cnt_q != 8'hFF) begin
            spur_cnt_q <= spur_cnt_q + 8'd1;
        end
    end

    assign spur_cnt = spur_cnt_q;
`else
    assign spur_cnt = 8'h00;
`endif

    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign err          = err_q;
    assign reloads_done = reloads_done_q;

endmodule

// File: tb/tb_timer_reload_seq.sv
// Directed scoreboard bench for timer_reload_seq: expected APB transfers are queued
// with each stimulus step and popped as the slave model completes each transfer.
module tb_timer_reload_seq;

    localparam logic [7:0] A_TDR = 8'h00;
    localparam logic [7:0] A_TCR = 8'h01;
    localparam logic [7:0] A_TSR = 8'h02;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       arm, stop, tmr_ovf, tmr_udf;
    logic [7:0] reload_val, tcr_val, reload_cnt;
    logic       busy, done, err;
    logic [7:0] spur_cnt, reloads_done;

    int checks = 0;
    int errors = 0;
    int doneCount = 0;
    logic doneBusy = 1'b1;

    int         waitStates = 0;
    int         accCnt = 0;
    logic [7:0] tsrReadVal = 8'h00;
    logic       errArm = 1'b0;
    logic [7:0] errAddr = 8'h00;
    logic [7:0] errData = 8'h00;

    logic [16:0] expQ[$];

    timer_reload_seq_if apb ();

    timer_reload_seq dut (
        .pclk         (pclk),
        .presetn      (presetn),
        .arm          (arm),
        .stop         (stop),
        .reload_val   (reload_val),
        .tcr_val      (tcr_val),
        .reload_cnt   (reload_cnt),
        .tmr_ovf      (tmr_ovf),
        .tmr_udf      (tmr_udf),
        .apb          (apb),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .spur_cnt     (spur_cnt),
        .reloads_done (reloads_done)
    );

    always #5 pclk = ~pclk;

    // Slave model plus scoreboard: decides pready for the coming edge and retires a transfer.
    initial begin
        logic [16:0] obsKey, expKey;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        apb.prdata  = 8'h00;
        forever begin
            @(negedge pclk);
            apb.prdata = tsrReadVal;
            if (apb.psel && apb.penable) begin
                apb.pready = (accCnt >= waitStates);
                accCnt++;
            end else begin
                apb.pready = 1'b0;
                accCnt = 0;
            end
            apb.pslverr = 1'b0;
            if (apb.pready) begin
                if (errArm && apb.paddr == errAddr && apb.pwrite && apb.pwdata == errData) begin
                    apb.pslverr = 1'b1;
                    errArm = 1'b0;
                end
                obsKey = {apb.pwrite, apb.paddr, apb.pwrite ? apb.pwdata : 8'h00};
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $error("[TB] FAIL unexpectedXfer: observed %h expected none", obsKey);
                end else begin
                    expKey = expQ.pop_front();
                    assert (obsKey === expKey) else begin
                        errors++;
                        $error("[TB] FAIL apbXfer: observed %h expected %h", obsKey, expKey);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge pclk);
            if (done) begin
                doneCount++;
                doneBusy = busy;
            end
        end
    end

    task automatic tick();
        @(negedge pclk);
        #1;
    endtask

    task automatic pushWr(input logic [7:0] addr, input logic [7:0] data);
        expQ.push_back({1'b1, addr, data});
    endtask

    task automatic pushRd(input logic [7:0] addr);
        expQ.push_back({1'b0, addr, 8'h00});
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] rv, input logic [7:0] tv, input logic [7:0] rc);
        reload_val = rv;
        tcr_val    = tv;
        reload_cnt = rc;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    task automatic pulseEvent(input logic ovf, input logic udf, input logic stp);
        tmr_ovf = ovf;
        tmr_udf = udf;
        stop    = stp;
        tick();
        tmr_ovf = 1'b0;
        tmr_udf = 1'b0;
        stop    = 1'b0;
    endtask

    task automatic waitQueueEmpty(input string tag, input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, 16'(expQ.size()), 16'd0);
    endtask

    task automatic pushReloadPass(input logic [7:0] rv, input logic [7:0] tv);
`ifdef TIMER_RELOAD_SEQ_SPUR_CHK_EN
        pushRd(A_TSR);
`endif
        pushWr(A_TSR, 8'h00);
        pushWr(A_TDR, rv);
        pushWr(A_TCR, tv | 8'h80);
        pushWr(A_TCR, (tv & 8'h7F) | 8'h10);
    endtask

    initial begin
        bit found;
        presetn = 1'b0;
        arm = 1'b0; stop = 1'b0; tmr_ovf = 1'b0; tmr_udf = 1'b0;
        reload_val = 8'h00; tcr_val = 8'h00; reload_cnt = 8'h00;
        repeat (3) tick();
        checkOutput("rstOutputs", {9'h0, busy, done, err, apb.psel, apb.penable, apb.pwrite, 1'b0},
                    16'h0000);
        checkOutput("rstCounters", {spur_cnt, reloads_done}, 16'h0000);
        presetn = 1'b1;
        tick();

        $display("[TB] count-limited reload sequence");
        pushWr(A_TDR, 8'hF0);
        pushWr(A_TCR, 8'h80);
        pushWr(A_TCR, 8'h10);
        applyStimulus(8'hF0, 8'h00, 8'd2);
        checkOutput("armLatency", {13'h0, busy, apb.psel, apb.penable}, 16'h0006);
        checkOutput("armAddr", {8'h00, apb.paddr}, {8'h00, A_TDR});
        waitQueueEmpty("initialArm", 50);
        tick();
        tsrReadVal = 8'h01;
        pushReloadPass(8'hF0, 8'h00);
        pulseEvent(1'b1, 1'b0, 1'b0);
        waitQueueEmpty("event1", 50);
        tick();
        checkOutput("reloads1", {8'h00, reloads_done}, 16'd1);
        pushReloadPass(8'hF0, 8'h00);
        pulseEvent(1'b1, 1'b0, 1'b0);
        waitQueueEmpty("event2", 50);
        tick();
        checkOutput("reloads2", {8'h00, reloads_done}, 16'd2);
`ifdef TIMER_RELOAD_SEQ_SPUR_CHK_EN
        pushRd(A_TSR);
`endif
        pushWr(A_TSR, 8'h00);
        pushWr(A_TCR, 8'h00);
        tsrReadVal = 8'h03;
        pulseEvent(1'b1, 1'b1, 1'b0);
        waitQueueEmpty("event3", 50);
        tick();
        checkOutput("doneCount", 16'(doneCount), 16'd1);
        checkOutput("doneWithIdle", {15'h0, doneBusy}, 16'h0000);
        checkOutput("finalIdle", {8'h00, 7'h0, busy}, 16'h0000);
        checkOutput("finalReloads", {8'h00, reloads_done}, 16'd2);

        $display("[TB] spurious event and stop in WAIT");
        pushWr(A_TDR, 8'h33);
        pushWr(A_TCR, 8'hA1);
        pushWr(A_TCR, 8'h31);
        applyStimulus(8'h33, 8'h21, 8'd0);
        waitQueueEmpty("arm2", 50);
        tick();
        tsrReadVal = 8'h00;
`ifdef TIMER_RELOAD_SEQ_SPUR_CHK_EN
        pushRd(A_TSR);
        pulseEvent(1'b0, 1'b1, 1'b0);
        waitQueueEmpty("spurRead", 50);
        repeat (2) tick();
        checkOutput("spurCnt", {8'h00, spur_cnt}, 16'd1);
        checkOutput("spurReloads", {8'h00, reloads_done}, 16'd0);
`else
        pushReloadPass(8'h33, 8'h21);
        pulseEvent(1'b0, 1'b1, 1'b0);
        waitQueueEmpty("noChkClear", 50);
        repeat (2) tick();
        checkOutput("spurCnt", {8'h00, spur_cnt}, 16'd0);
        checkOutput("noChkReloads", {8'h00, reloads_done}, 16'd1);
`endif
        checkOutput("stillBusy", {15'h0, busy}, 16'h0001);
        tsrReadVal = 8'h01;
        pushWr(A_TCR, 8'h21);
        pulseEvent(1'b1, 1'b0, 1'b1);
        waitQueueEmpty("stopOff", 50);
        repeat (2) tick();
        checkOutput("stopIdle", {15'h0, busy}, 16'h0000);
        checkOutput("stopNoDone", 16'(doneCount), 16'd1);

        $display("[TB] slave error on load write");
        errArm  = 1'b1;
        errAddr = A_TCR;
        errData = 8'h80;
        pushWr(A_TDR, 8'h10);
        pushWr(A_TCR, 8'h80);
        applyStimulus(8'h10, 8'h00, 8'd1);
        waitQueueEmpty("errXfers", 50);
        tick();
        checkOutput("errAbort", {13'h0, apb.psel, err, busy}, 16'h0002);
        repeat (3) tick();
        checkOutput("errSticky", {14'h0, err, apb.psel}, 16'h0002);
        checkOutput("errNoDone", 16'(doneCount), 16'd1);

        $display("[TB] wait states, ignored re-arm and reset mid-access");
        waitStates = 3;
        pushWr(A_TDR, 8'h77);
        pushWr(A_TCR, 8'h80);
        pushWr(A_TCR, 8'h10);
        applyStimulus(8'h77, 8'h00, 8'd0);
        checkOutput("armClearsErr", {15'h0, err}, 16'h0000);
        reload_val = 8'hEE;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        waitQueueEmpty("waitArm", 100);
        tick();
        tsrReadVal = 8'h02;
        pushReloadPass(8'h77, 8'h00);
        pulseEvent(1'b1, 1'b0, 1'b0);
        waitQueueEmpty("waitEvent", 150);
        tick();
        checkOutput("waitReloads", {spur_cnt, reloads_done}, 16'h0001);
        pulseEvent(1'b1, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (apb.psel && apb.penable) found = 1'b1;
            else tick();
        end
        checkOutput("reachAccess", {15'h0, found}, 16'h0001);
        presetn = 1'b0;
        #1;
        checkOutput("rstMidBus", {11'h0, apb.psel, apb.penable, apb.pwrite, busy, err}, 16'h0000);
        checkOutput("rstMidData", {apb.paddr, apb.pwdata}, 16'h0000);
        checkOutput("rstMidCnt", {8'h00, reloads_done}, 16'h0000);
        expQ.delete();
        waitStates = 0;
        tick();
        presetn = 1'b1;
        repeat (3) tick();
        checkOutput("postRstIdle", {14'h0, busy, apb.psel}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL timeout: observed no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
